// File: rtl/decode_queue.sv
// Buffered ARM-style instruction decode stage: a DEPTH-entry valid/ready FIFO feeding a
// registered output stage that carries type/subtype classification and the condition result.
module decode_queue #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 32,
  parameter int COND_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [3:0]                 flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [TAG_W-1:0]           out_tag,
  output logic [1:0]                 instr_type,
  output logic [2:0]                 data_instr_type,
  output logic [1:0]                 mem_instr_type,
  output logic [1:0]                 jmp_instr_type,
  output logic                       cond_pass,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [31:0]      fifo_instr [DEPTH];
  logic [TAG_W-1:0] fifo_tag   [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;

  logic push_ok, pop, bypass, wr_en, load, out_free, fifo_empty;

  logic [31:0]      ld_instr_p0;
  logic [TAG_W-1:0] ld_tag_p0;
  logic [1:0]       ld_type_p0;
  logic [2:0]       ld_data_p0;
  logic [1:0]       ld_mem_p0;
  logic [1:0]       ld_jmp_p0;
  logic             ld_cond_p0;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = !z;
      4'h2:    cond_eval = c;
      4'h3:    cond_eval = !c;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = !n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = !v;
      4'h8:    cond_eval = c & !z;
      4'h9:    cond_eval = !c | z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = !z & (n == v);
      4'hD:    cond_eval = z | (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] data_sub(input logic b25, input logic b7, input logic b4);
    if (b25)      data_sub = 3'b001;
    else if (!b4) data_sub = 3'b010;
    else if (b7)  data_sub = 3'b011;
    else          data_sub = 3'b100;
  endfunction

  // in_ready depends on the registered count only, so a full queue never admits a push
  assign in_ready   = (count != LW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign out_free   = !out_valid || out_ready;
  assign push_ok    = in_valid && in_ready && !flush;
  assign pop        = out_free && !fifo_empty && !flush;
  assign bypass     = push_ok && fifo_empty && out_free;
  assign wr_en      = push_ok && !bypass;
  assign load       = pop || bypass;
  assign level      = count;

  // Stage p0: select the entry being loaded and decode it
  always_comb begin
    ld_instr_p0 = pop ? fifo_instr[rd_ptr] : in_instr;
    ld_tag_p0   = pop ? fifo_tag[rd_ptr]   : in_tag;
    ld_type_p0  = 2'b00;
    ld_data_p0  = 3'b000;
    ld_mem_p0   = 2'b00;
    ld_jmp_p0   = 2'b00;
    case (ld_instr_p0[27:26])
      2'b00: begin
        ld_type_p0 = 2'b01;
        ld_data_p0 = data_sub(ld_instr_p0[25], ld_instr_p0[7], ld_instr_p0[4]);
      end
      2'b01: begin
        ld_type_p0 = 2'b10;
        ld_mem_p0  = ld_instr_p0[25] ? 2'b10 : 2'b01;
      end
      2'b10: begin
        ld_type_p0 = 2'b11;
        ld_jmp_p0  = ld_instr_p0[25] ? (ld_instr_p0[24] ? 2'b10 : 2'b01) : 2'b00;
      end
      default: ld_type_p0 = 2'b00;
    endcase
    ld_cond_p0 = (COND_EN != 0) ? cond_eval(ld_instr_p0[31:28], flags) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_instr[wr_ptr] <= in_instr;
      fifo_tag[wr_ptr]   <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count <= count + LW'(wr_en) - LW'(pop);
    end
  end

  // Stage p1: registered decode record presented to execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_instr       <= '0;
      out_tag         <= '0;
      instr_type      <= '0;
      data_instr_type <= '0;
      mem_instr_type  <= '0;
      jmp_instr_type  <= '0;
      cond_pass       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid       <= 1'b1;
      out_instr       <= ld_instr_p0;
      out_tag         <= ld_tag_p0;
      instr_type      <= ld_type_p0;
      data_instr_type <= ld_data_p0;
      mem_instr_type  <= ld_mem_p0;
      jmp_instr_type  <= ld_jmp_p0;
      cond_pass       <= ld_cond_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus pushes hand-computed records, a negedge
// monitor pops and compares each accepted output record.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 32;
  localparam int LW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [TAG_W-1:0] in_tag;
  logic [3:0] flags;

  logic in_ready, out_valid, cond_pass;
  logic [31:0] out_instr;
  logic [TAG_W-1:0] out_tag;
  logic [1:0] instr_type, mem_instr_type, jmp_instr_type;
  logic [2:0] data_instr_type;
  logic [LW-1:0] level;

  logic in_ready2, out_valid2, cond_pass2;
  logic [31:0] out_instr2;
  logic [TAG_W-1:0] out_tag2;
  logic [1:0] instr_type2, mem_instr_type2, jmp_instr_type2;
  logic [2:0] data_instr_type2;
  logic [LW-1:0] level2;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .COND_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .flags(flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_tag(out_tag), .instr_type(instr_type),
    .data_instr_type(data_instr_type), .mem_instr_type(mem_instr_type),
    .jmp_instr_type(jmp_instr_type), .cond_pass(cond_pass), .level(level));

  decode_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .COND_EN(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_tag(in_tag), .flags(flags), .out_valid(out_valid2),
    .out_ready(out_ready), .out_instr(out_instr2), .out_tag(out_tag2), .instr_type(instr_type2),
    .data_instr_type(data_instr_type2), .mem_instr_type(mem_instr_type2),
    .jmp_instr_type(jmp_instr_type2), .cond_pass(cond_pass2), .level(level2));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] tag;
    logic [1:0]  ty;
    logic [2:0]  ds;
    logic [1:0]  ms;
    logic [1:0]  js;
    logic        cp;
  } rec_t;

  rec_t sb[$];
  rec_t e;
  int nchecks = 0;
  int errors  = 0;
  int npop    = 0;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      nchecks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got instr=%h tag=%h, required none", out_instr, out_tag);
      end else begin
        e = sb.pop_front();
        npop++;
        if (out_instr !== e.instr || out_tag !== e.tag || instr_type !== e.ty ||
            data_instr_type !== e.ds || mem_instr_type !== e.ms ||
            jmp_instr_type !== e.js || cond_pass !== e.cp) begin
          errors++;
          $display("FAIL record: got %h/%h t%b d%b m%b j%b c%b, required %h/%h t%b d%b m%b j%b c%b",
                   out_instr, out_tag, instr_type, data_instr_type, mem_instr_type,
                   jmp_instr_type, cond_pass, e.instr, e.tag, e.ty, e.ds, e.ms, e.js, e.cp);
        end
        nchecks++;
        if (out_valid2 !== 1'b1 || out_instr2 !== e.instr || cond_pass2 !== 1'b1) begin
          errors++;
          $display("FAIL nocond_record: got v%b %h c%b, required v1 %h c1",
                   out_valid2, out_instr2, cond_pass2, e.instr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] tg, input logic [1:0] ty,
                      input logic [2:0] ds, input logic [1:0] ms, input logic [1:0] js,
                      input logic cp, output int cyc);
    logic rdy;
    rec_t r;
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tg;
    cyc      = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      cyc++;
    end while (!rdy && cyc < 50);
    if (!rdy) begin
      chk("push_timeout", 64'(cyc), 64'(0));
    end else begin
      r.instr = ins; r.tag = tg; r.ty = ty; r.ds = ds; r.ms = ms; r.js = js; r.cp = cp;
      sb.push_back(r);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_level"}, 64'(level), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_out_instr"}, 64'(out_instr), 64'(0));
    chk({tag, "_out_tag"}, 64'(out_tag), 64'(0));
    chk({tag, "_decode"}, 64'({instr_type, data_instr_type, mem_instr_type,
                               jmp_instr_type, cond_pass}), 64'(0));
  endtask

  initial begin
    int cyc;
    int np0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_tag = '0; flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: bypass latency
    chk("pre_push_out_valid", 64'(out_valid), 64'(0));
    push(32'hE2811001, 32'd100, 2'b01, 3'b001, 2'b00, 2'b00, 1'b1, cyc);
    chk("t1_out_valid", 64'(out_valid), 64'(1));
    chk("t1_type", 64'(instr_type), 64'(2'b01));
    chk("t1_data", 64'(data_instr_type), 64'(3'b001));
    chk("t1_cond", 64'(cond_pass), 64'(1));
    chk("t1_level", 64'(level), 64'(0));
    @(posedge clk); #1;
    chk("t1_consumed", 64'(out_valid), 64'(0));

    // Test 2: fill to DEPTH+1 with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      push(32'hE2811000 + 32'(i), 32'd200 + 32'(i), 2'b01, 3'b001, 2'b00, 2'b00, 1'b1, cyc);
    chk("t2_level_full", 64'(level), 64'(DEPTH));
    chk("t2_in_ready", 64'(in_ready), 64'(0));
    chk("t2_out_valid", 64'(out_valid), 64'(1));
    repeat (3) @(posedge clk);
    #1 chk("t2_held_instr", 64'(out_instr), 64'(32'hE2811000));
    in_valid = 1'b1; in_instr = 32'hE2811010; in_tag = 32'd299; out_ready = 1'b1;
    sb.push_back('{32'hE2811010, 32'd299, 2'b01, 3'b001, 2'b00, 2'b00, 1'b1});
    @(posedge clk); #1;
    chk("t2_full_pop_no_push", 64'(level), 64'(DEPTH - 1));
    chk("t2_in_ready_after", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    chk("t2_push_pop_level", 64'(level), 64'(DEPTH - 1));
    in_valid = 1'b0;
    drain();

    // Test 3: memory, branch and data subtypes
    push(32'hE5910000, 32'd300, 2'b10, 3'b000, 2'b01, 2'b00, 1'b1, cyc);
    push(32'hE7910002, 32'd301, 2'b10, 3'b000, 2'b10, 2'b00, 1'b1, cyc);
    push(32'hEB000010, 32'd302, 2'b11, 3'b000, 2'b00, 2'b10, 1'b1, cyc);
    push(32'hEA000010, 32'd303, 2'b11, 3'b000, 2'b00, 2'b01, 1'b1, cyc);
    push(32'hE8BD0003, 32'd304, 2'b11, 3'b000, 2'b00, 2'b00, 1'b1, cyc);
    push(32'hE0810002, 32'd305, 2'b01, 3'b010, 2'b00, 2'b00, 1'b1, cyc);
    push(32'hE0010291, 32'd306, 2'b01, 3'b011, 2'b00, 2'b00, 1'b1, cyc);
    push(32'hE0810312, 32'd307, 2'b01, 3'b100, 2'b00, 2'b00, 1'b1, cyc);
    push(32'hEC000000, 32'd308, 2'b00, 3'b000, 2'b00, 2'b00, 1'b1, cyc);
    drain();

    // Test 4: condition codes
    flags = 4'b0100;
    push(32'h0A000000, 32'd400, 2'b11, 3'b000, 2'b00, 2'b01, 1'b1, cyc);
    push(32'h1A000000, 32'd401, 2'b11, 3'b000, 2'b00, 2'b01, 1'b0, cyc);
    push(32'hF2800000, 32'd402, 2'b01, 3'b001, 2'b00, 2'b00, 1'b0, cyc);
    drain();
    flags = 4'b1001;
    push(32'hAA000000, 32'd410, 2'b11, 3'b000, 2'b00, 2'b01, 1'b1, cyc);
    push(32'hCA000000, 32'd411, 2'b11, 3'b000, 2'b00, 2'b01, 1'b1, cyc);
    push(32'hBA000000, 32'd412, 2'b11, 3'b000, 2'b00, 2'b01, 1'b0, cyc);
    push(32'h8A000000, 32'd413, 2'b11, 3'b000, 2'b00, 2'b01, 1'b0, cyc);
    push(32'h9A000000, 32'd414, 2'b11, 3'b000, 2'b00, 2'b01, 1'b1, cyc);
    drain();
    out_ready = 1'b0; flags = 4'b0100;
    push(32'h0A000000, 32'd420, 2'b11, 3'b000, 2'b00, 2'b01, 1'b1, cyc);
    flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Test 5: flush with a push in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'hE2811100 + 32'(i), 32'd500 + 32'(i), 2'b01, 3'b001, 2'b00, 2'b00, 1'b1, cyc);
    chk("t5_level_before", 64'(level), 64'(2));
    in_valid = 1'b1; in_instr = 32'hE2811FFF; in_tag = 32'd599; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("t5_out_valid", 64'(out_valid), 64'(0));
    chk("t5_level", 64'(level), 64'(0));
    chk("t5_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 push(32'hE2811200, 32'd510, 2'b01, 3'b001, 2'b00, 2'b00, 1'b1, cyc);
    drain();

    // Test 6: full throughput with one entry resident, wrapping the pointers
    out_ready = 1'b0;
    push(32'hE3A00100, 32'd600, 2'b01, 3'b001, 2'b00, 2'b00, 1'b1, cyc);
    push(32'hE3A00101, 32'd601, 2'b01, 3'b001, 2'b00, 2'b00, 1'b1, cyc);
    out_ready = 1'b1;
    np0 = npop;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      push(32'hE3A00000 + 32'(i), 32'd610 + 32'(i), 2'b01, 3'b001, 2'b00, 2'b00, 1'b1, cyc);
      chk("t6_one_cycle", 64'(cyc), 64'(1));
      chk("t6_level", 64'(level), 64'(1));
    end
    chk("t6_records_per_cycle", 64'(npop - np0), 64'(3 * DEPTH));
    drain();

    // Mid-stream asynchronous reset
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'hE3A00200 + 32'(i), 32'd700 + 32'(i), 2'b01, 3'b001, 2'b00, 2'b00, 1'b1, cyc);
    rst_n = 1'b0;
    sb.delete();
    #1 chk_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    push(32'hE3A00300, 32'd800, 2'b01, 3'b001, 2'b00, 2'b00, 1'b1, cyc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, errors);
    $finish;
  end

endmodule
